// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: shares one write port between the ALU result
// path (req0, with backpressure) and load returns (req1) buffered in a 2-entry FIFO.
module regfile_wb_arbiter #(
    parameter int AWIDTH   = 5,
    parameter int DWIDTH   = 32,
    parameter int LQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              req0_valid,
    input  logic [AWIDTH-1:0] req0_addr,
    input  logic [DWIDTH-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [AWIDTH-1:0] req1_addr,
    input  logic [DWIDTH-1:0] req1_data,
    output logic              wb_en,
    output logic              wb_sel,
    output logic [AWIDTH-1:0] wb_addr,
    output logic [DWIDTH-1:0] wb_data,
    output logic [1:0]        lq_count,
    output logic              overflow
);

    localparam logic [1:0] LQ_FULL = 2'(LQ_DEPTH);

    logic [AWIDTH-1:0] lq_addr_q [2];
    logic [DWIDTH-1:0] lq_data_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q, count_d;
    logic              ptr_q, ptr_d;
    logic              overflow_q;
    logic              wb_en_q, wb_sel_q;
    logic [AWIDTH-1:0] wb_addr_q;
    logic [DWIDTH-1:0] wb_data_q;

    logic              cand_a, cand_l;
    logic              grant_a, grant_l, grant;
    logic              push_ok, drop;
    logic [AWIDTH-1:0] win_addr;
    logic [DWIDTH-1:0] win_data;

    // An empty FIFO offers no candidate, so a load arriving into it waits a cycle.
    assign cand_a = req0_valid;
    assign cand_l = (count_q != 2'd0);
    assign grant  = grant_a | grant_l;

    always_comb begin
        grant_a = 1'b0;
        grant_l = 1'b0;
        if (!hold) begin
            if (count_q == LQ_FULL) begin
                grant_l = 1'b1;
            end else if (cand_a && cand_l) begin
                grant_l = ptr_q;
                grant_a = !ptr_q;
            end else begin
                grant_a = cand_a;
                grant_l = cand_l;
            end
        end
    end

    always_comb begin
        push_ok = req1_valid && ((count_q != LQ_FULL) || grant_l);
        drop    = req1_valid && (count_q == LQ_FULL) && !grant_l;
        count_d = count_q;
        case ({push_ok, grant_l})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        ptr_d = ptr_q;
        if (grant_a)      ptr_d = 1'b1;
        else if (grant_l) ptr_d = 1'b0;
        win_addr = grant_l ? lq_addr_q[rd_ptr_q] : req0_addr;
        win_data = grant_l ? lq_data_q[rd_ptr_q] : req0_data;
    end

    // FIFO storage carries no reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            lq_addr_q[wr_ptr_q] <= req1_addr;
            lq_data_q[wr_ptr_q] <= req1_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            ptr_q      <= 1'b0;
            overflow_q <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_sel_q   <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= ~wr_ptr_q;
            if (grant_l) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
            ptr_q   <= ptr_d;
            if (drop) overflow_q <= 1'b1;
            // Writes to register 0 are consumed but never enabled.
            wb_en_q <= grant && (win_addr != '0);
            if (grant) begin
                wb_sel_q  <= grant_l;
                wb_addr_q <= win_addr;
                wb_data_q <= win_data;
            end
        end
    end

    assign req0_ready = grant_a;
    assign wb_en      = wb_en_q;
    assign wb_sel     = wb_sel_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign lq_count   = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter: one task per scenario, inline checks.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold = 1'b0;
    logic        req0_valid = 1'b0;
    logic [4:0]  req0_addr = '0;
    logic [31:0] req0_data = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [4:0]  req1_addr = '0;
    logic [31:0] req1_data = '0;
    logic        wb_en, wb_sel;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [1:0]  lq_count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.AWIDTH(5), .DWIDTH(32), .LQ_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
        .wb_en(wb_en), .wb_sel(wb_sel), .wb_addr(wb_addr), .wb_data(wb_data),
        .lq_count(lq_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Requester-rule monitor: a pending req0 must hold valid/addr/data until ready.
    logic        pend = 1'b0;
    logic [4:0]  pend_addr;
    logic [31:0] pend_data;
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend && (req0_valid !== 1'b1 || req0_addr !== pend_addr || req0_data !== pend_data)) begin
                errors++;
                $display("FAIL req0_stable got v=%0b a=%0d d=%h want v=1 a=%0d d=%h",
                         req0_valid, req0_addr, req0_data, pend_addr, pend_data);
            end
            pend      = req0_valid && !req0_ready;
            pend_addr = req0_addr;
            pend_data = req0_data;
        end
    end

    // One line per register-file write.
    always @(negedge clk) begin
        if (rst_n && wb_en)
            $display("WB sel=%0b addr=%0d data=%h lq_count=%0d", wb_sel, wb_addr, wb_data, lq_count);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; hold = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = '0; req0_data = '0; req1_addr = '0; req1_data = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en got %0b want 0", wb_en); end
        checks++; if (wb_sel !== 1'b0) begin errors++; $display("FAIL reset_wb_sel got %0b want 0", wb_sel); end
        checks++; if (wb_addr !== 5'd0) begin errors++; $display("FAIL reset_wb_addr got %0d want 0", wb_addr); end
        checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb_data got %h want 0", wb_data); end
        checks++; if (lq_count !== 2'd0) begin errors++; $display("FAIL reset_lq_count got %0d want 0", lq_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", req0_ready); end
    endtask

    task automatic test_alu_single();
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h11;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got %0b want 1", req0_ready); end
        step();
        req0_valid = 1'b0;
        checks++; if ({wb_en, wb_sel, wb_addr, wb_data} !== {1'b1, 1'b0, 5'd5, 32'h11}) begin
            errors++; $display("FAIL alu_write got en=%0b sel=%0b a=%0d d=%h want en=1 sel=0 a=5 d=11", wb_en, wb_sel, wb_addr, wb_data); end
        step();
        checks++; if ({wb_en, wb_addr, wb_data} !== {1'b0, 5'd5, 32'h11}) begin
            errors++; $display("FAIL alu_idle_hold got en=%0b a=%0d d=%h want en=0 a=5 d=11", wb_en, wb_addr, wb_data); end
    endtask

    task automatic test_alu_then_load();
        do_reset();
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hB;
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hA;
        #1;
        checks++; if (lq_count !== 2'd1) begin errors++; $display("FAIL rr_count got %0d want 1", lq_count); end
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rr_ready_ptr0 got %0b want 1", req0_ready); end
        step();
        req0_valid = 1'b0;
        checks++; if ({wb_en, wb_sel, wb_addr, wb_data} !== {1'b1, 1'b0, 5'd3, 32'hA}) begin
            errors++; $display("FAIL rr_first got en=%0b sel=%0b a=%0d d=%h want en=1 sel=0 a=3 d=a", wb_en, wb_sel, wb_addr, wb_data); end
        step();
        checks++; if ({wb_en, wb_sel, wb_addr, wb_data, lq_count} !== {1'b1, 1'b1, 5'd7, 32'hB, 2'd0}) begin
            errors++; $display("FAIL rr_second got en=%0b sel=%0b a=%0d d=%h cnt=%0d want en=1 sel=1 a=7 d=b cnt=0", wb_en, wb_sel, wb_addr, wb_data, lq_count); end
        // After the load grant the pointer prefers the ALU again.
        req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'hC;
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'hD;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rr_ptr_end got %0b want 1", req0_ready); end
        step();
        req0_valid = 1'b0;
        checks++; if ({wb_sel, wb_addr} !== {1'b0, 5'd4}) begin errors++; $display("FAIL rr_third got sel=%0b a=%0d want sel=0 a=4", wb_sel, wb_addr); end
        step();
        checks++; if ({wb_en, wb_sel, wb_addr, wb_data} !== {1'b1, 1'b1, 5'd9, 32'hC}) begin
            errors++; $display("FAIL rr_fourth got en=%0b sel=%0b a=%0d d=%h want en=1 sel=1 a=9 d=c", wb_en, wb_sel, wb_addr, wb_data); end
    endtask

    task automatic test_overflow();
        do_reset();
        hold = 1'b1;
        req1_valid = 1'b1; req1_addr = 5'd1; req1_data = 32'h101;
        step();
        checks++; if (lq_count !== 2'd1) begin errors++; $display("FAIL ovf_count1 got %0d want 1", lq_count); end
        req1_addr = 5'd2; req1_data = 32'h202;
        step();
        checks++; if ({lq_count, overflow} !== {2'd2, 1'b0}) begin errors++; $display("FAIL ovf_count2 got cnt=%0d ovf=%0b want cnt=2 ovf=0", lq_count, overflow); end
        req1_addr = 5'd3; req1_data = 32'h303;
        step();
        checks++; if ({lq_count, overflow, wb_en} !== {2'd2, 1'b1, 1'b0}) begin
            errors++; $display("FAIL ovf_drop got cnt=%0d ovf=%0b en=%0b want cnt=2 ovf=1 en=0", lq_count, overflow, wb_en); end
        req1_valid = 1'b0; hold = 1'b0;
        step();
        checks++; if ({wb_en, wb_sel, wb_addr, wb_data, lq_count} !== {1'b1, 1'b1, 5'd1, 32'h101, 2'd1}) begin
            errors++; $display("FAIL ovf_drain1 got en=%0b sel=%0b a=%0d d=%h cnt=%0d want en=1 sel=1 a=1 d=101 cnt=1", wb_en, wb_sel, wb_addr, wb_data, lq_count); end
        step();
        checks++; if ({wb_en, wb_sel, wb_addr, wb_data, lq_count, overflow} !== {1'b1, 1'b1, 5'd2, 32'h202, 2'd0, 1'b1}) begin
            errors++; $display("FAIL ovf_drain2 got en=%0b sel=%0b a=%0d d=%h cnt=%0d ovf=%0b want en=1 sel=1 a=2 d=202 cnt=0 ovf=1", wb_en, wb_sel, wb_addr, wb_data, lq_count, overflow); end
        step();
        checks++; if ({wb_en, overflow} !== {1'b0, 1'b1}) begin errors++; $display("FAIL ovf_after got en=%0b ovf=%0b want en=0 ovf=1", wb_en, overflow); end
    endtask

    task automatic test_forced_drain();
        do_reset();
        hold = 1'b1;
        req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'hAA;
        step();
        req1_addr = 5'd11; req1_data = 32'hBB;
        step();
        // Release hold with a third load arriving in the same cycle as the first pop.
        hold = 1'b0;
        req1_addr = 5'd13; req1_data = 32'hDD;
        req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'hCC;
        #1;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL drain_ready1 got %0b want 0", req0_ready); end
        step();
        req1_valid = 1'b0;
        checks++; if ({wb_sel, wb_addr, lq_count, overflow} !== {1'b1, 5'd10, 2'd2, 1'b0}) begin
            errors++; $display("FAIL drain_w1 got sel=%0b a=%0d cnt=%0d ovf=%0b want sel=1 a=10 cnt=2 ovf=0", wb_sel, wb_addr, lq_count, overflow); end
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL drain_ready2 got %0b want 0", req0_ready); end
        step();
        checks++; if ({wb_sel, wb_addr, wb_data, lq_count} !== {1'b1, 5'd11, 32'hBB, 2'd1}) begin
            errors++; $display("FAIL drain_w2 got sel=%0b a=%0d d=%h cnt=%0d want sel=1 a=11 d=bb cnt=1", wb_sel, wb_addr, wb_data, lq_count); end
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL drain_ready3 got %0b want 1", req0_ready); end
        step();
        req0_valid = 1'b0;
        checks++; if ({wb_en, wb_sel, wb_addr, wb_data} !== {1'b1, 1'b0, 5'd12, 32'hCC}) begin
            errors++; $display("FAIL drain_alu got en=%0b sel=%0b a=%0d d=%h want en=1 sel=0 a=12 d=cc", wb_en, wb_sel, wb_addr, wb_data); end
        step();
        checks++; if ({wb_en, wb_sel, wb_addr, wb_data, lq_count} !== {1'b1, 1'b1, 5'd13, 32'hDD, 2'd0}) begin
            errors++; $display("FAIL drain_w3 got en=%0b sel=%0b a=%0d d=%h cnt=%0d want en=1 sel=1 a=13 d=dd cnt=0", wb_en, wb_sel, wb_addr, wb_data, lq_count); end
    endtask

    task automatic test_reg_zero();
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hFF;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %0b want 1", req0_ready); end
        step();
        req0_valid = 1'b0;
        checks++; if ({wb_en, wb_sel, wb_addr, wb_data} !== {1'b0, 1'b0, 5'd0, 32'hFF}) begin
            errors++; $display("FAIL r0_write got en=%0b sel=%0b a=%0d d=%h want en=0 sel=0 a=0 d=ff", wb_en, wb_sel, wb_addr, wb_data); end
        // Pointer toggled to the load source: a contended cycle must favour the load.
        req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h66;
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd8; req0_data = 32'h88;
        #1;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL r0_ptr got %0b want 0", req0_ready); end
        step();
        checks++; if ({wb_en, wb_sel, wb_addr, wb_data} !== {1'b1, 1'b1, 5'd6, 32'h66}) begin
            errors++; $display("FAIL r0_load got en=%0b sel=%0b a=%0d d=%h want en=1 sel=1 a=6 d=66", wb_en, wb_sel, wb_addr, wb_data); end
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL r0_ready2 got %0b want 1", req0_ready); end
        step();
        req0_valid = 1'b0;
        checks++; if ({wb_en, wb_sel, wb_addr, wb_data} !== {1'b1, 1'b0, 5'd8, 32'h88}) begin
            errors++; $display("FAIL r0_alu got en=%0b sel=%0b a=%0d d=%h want en=1 sel=0 a=8 d=88", wb_en, wb_sel, wb_addr, wb_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        hold = 1'b1;
        req1_valid = 1'b1; req1_addr = 5'd14; req1_data = 32'hE1;
        step();
        req1_addr = 5'd15; req1_data = 32'hE2;
        step();
        req1_addr = 5'd16; req1_data = 32'hE3;
        step();
        hold = 1'b0;
        req1_addr = 5'd17; req1_data = 32'hE4;
        step();
        req1_valid = 1'b0;
        checks++; if ({wb_en, wb_addr, lq_count, overflow} !== {1'b1, 5'd14, 2'd2, 1'b1}) begin
            errors++; $display("FAIL mid_setup got en=%0b a=%0d cnt=%0d ovf=%0b want en=1 a=14 cnt=2 ovf=1", wb_en, wb_addr, lq_count, overflow); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({wb_en, lq_count, overflow} !== {1'b0, 2'd0, 1'b0}) begin
            errors++; $display("FAIL mid_async got en=%0b cnt=%0d ovf=%0b want en=0 cnt=0 ovf=0", wb_en, lq_count, overflow); end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({wb_en, lq_count, overflow} !== {1'b0, 2'd0, 1'b0}) begin
                errors++; $display("FAIL mid_after%0d got en=%0b cnt=%0d ovf=%0b want en=0 cnt=0 ovf=0", i, wb_en, lq_count, overflow); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_alu_then_load();
        test_overflow();
        test_forced_drain();
        test_reg_zero();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single register-file write port and shares it between two writeback sources: the ALU result path (req0) and the load-return path (req1).
- req0 supports backpressure. req1 has none, so its returns are absorbed in a 2-entry FIFO.
- Grants one write per cycle and drives the select of the 5-bit destination-address mux (wb_sel) along with the registered write address and data.
- Sits between the execute/memory stages and the register file.

Parameters:
AWIDTH, 5, register address width
DWIDTH, 32, register data width
LQ_DEPTH, 2, load-return FIFO depth (fixed at 2; no other value supported)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
hold  in  1  when 1, no grants this cycle
req0_valid  in  1  ALU write request
req0_addr  in  AWIDTH  ALU destination register
req0_data  in  DWIDTH  ALU result
req0_ready  out  1  ALU request accepted this cycle (combinational)
req1_valid  in  1  load return, single-cycle pulse, no backpressure
req1_addr  in  AWIDTH  load destination register
req1_data  in  DWIDTH  load data
wb_en  out  1  register-file write enable
wb_sel  out  1  mux select: 0 = ALU source, 1 = load source
wb_addr  out  AWIDTH  write address
wb_data  out  DWIDTH  write data
lq_count  out  2  FIFO occupancy, 0..2
overflow  out  1  sticky: a load return was dropped

Behaviour:
- Reset (async, rst_n=0): wb_en=0, wb_sel=0, wb_addr=0, wb_data=0, lq_count=0, overflow=0, FIFO pointers=0, priority pointer ptr=0 (ALU preferred). Release is synchronous to clk.
- Load FIFO:
  - req1_valid pushes {addr,data} on the rising edge.
  - Pushes are accepted when count<2, or when count==2 and a pop happens in the same cycle (count stays 2).
  - A push at count==2 with no pop drops the entry and sets overflow=1 until reset.
- Head bypass: when count==0, a req1 arriving this cycle is not a FIFO head for arbitration. It enters the FIFO and competes from the next cycle. Load-to-write minimum latency is 2 cycles.
- Arbitration (combinational, per cycle), candidates are A = req0_valid and L = (count>0):
  - hold=1: no grant, req0_ready=0.
  - count==2: L wins unconditionally (forced drain).
  - Only A or only L: that one wins.
  - Both A and L: ptr decides (0 = A, 1 = L).
  - req0_ready = 1 iff A wins.
  - After any grant, ptr = the non-granted source (round-robin). No grant leaves ptr unchanged.
- Requester rule: req0_valid, req0_addr and req0_data hold stable until req0_ready. The bench flags violations; the RTL does not check them.
- Output register (1-cycle latency):
  - A grant at edge N drives wb_sel, wb_addr and wb_data from the winner, and wb_en=1, for cycle N+1.
  - No grant: wb_en=0. wb_sel, wb_addr and wb_data hold their previous values.
- Register $0: a grant with addr==0 is consumed normally (FIFO pop or req0_ready, ptr rotates, sel/addr/data load) but wb_en=0.
- Reset mid-operation: FIFO contents are discarded, any in-flight write is cancelled immediately (wb_en=0 asynchronously), and overflow is cleared.
- lq_count is registered and reflects post-edge occupancy.

Test Plan:
- Reset, then req0 {addr=5, data=0x11} with no load: req0_ready=1 same cycle. Next cycle wb_en=1, wb_sel=0, wb_addr=5, wb_data=0x11.
- req0 held valid {3, 0xA}, and a load {7, 0xB} arriving one cycle earlier (count=1, ptr=0): ALU is written first, then the load; wb_sel sequence 0,1; ptr ends at 0.
- Three back-to-back loads with hold=1: count goes 1,2,2 and overflow=1 after the third. hold=0 then drains 2 writes with wb_sel=1 and original addr/data order; overflow stays 1.
- count=2 and req0 valid continuously: the two loads win consecutively (forced drain), then req0 is granted; req0_ready=0 for 2 cycles.
- req0 {addr=0, data=0xFF}: req0_ready=1, next cycle wb_en=0, wb_addr=0; ptr toggles.
- rst_n pulsed low while count=2 and wb_en=1: wb_en=0 immediately, lq_count=0 and overflow=0 after release, and no stale writes afterwards.
